usb_tx_pkt_ctrl: RTL

USB_TX_PKT_CTRL -- requirements
Module: usb_tx_pkt_ctrl

---
 rtl/usb_pkg.sv | 30 +++
 rtl/usb_tx_byte_shifter.sv | 43 ++++
 rtl/usb_tx_pkt_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_pkg : shared types and constants for the USB packet transmitter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PID  = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4,
    ST_EOP  = 3'd5
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE     = 8'h80;
  localparam logic [7:0] J_BYTE        = 8'hFF;
  localparam logic [1:0] KIND_PID_ONLY = 2'b00;
  localparam logic [1:0] KIND_DATA     = 2'b01;
  localparam logic [1:0] KIND_ZLP      = 2'b10;
  localparam logic [1:0] KIND_RSVD     = 2'b11;
  localparam int         EOP_BITS      = 3;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_byte_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_byte_shifter : LSB-first byte shift register with bit counter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module usb_tx_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_shift,
  output logic       o_bit,
  output logic [2:0] o_cnt,
  output logic       o_last_bit
);

  logic [7:0] r_sr;
  logic [2:0] r_cnt;
  logic       r_bit;

  // r_bit idles at J so the line is correct straight out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= 8'h00;
      r_cnt <= 3'd0;
      r_bit <= 1'b1;
    end else if (i_load) begin
      r_sr  <= i_byte;
      r_bit <= i_byte[0];
      r_cnt <= 3'd0;
    end else if (i_shift) begin
      r_sr  <= {1'b0, r_sr[7:1]};
      r_bit <= r_sr[1];
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_bit      = r_bit;
  assign o_cnt      = r_cnt;
  assign o_last_bit = i_shift & (r_cnt == 3'd7);

endmodule
`default_nettype wire

// File: rtl/usb_tx_pkt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_pkt_ctrl : sequences SYNC, PID, payload, CRC16 and EOP bits    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module usb_tx_pkt_ctrl
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_start,
  input  logic [3:0]  pkt_pid,
  input  logic [1:0]  pkt_kind,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  input  logic        tx_shift,
  input  logic        tx_hold,
  input  logic [15:0] crc_16,
  output logic        crc_clear,
  output logic        crc_enable,
  output logic        tx_out_bit,
  output logic        eop_active,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        underrun
);

  tx_state_t  r_state, w_state_nxt;
  logic [3:0] r_pid;
  logic [1:0] r_kind;
  logic       r_last;
  logic [7:0] r_crc_lo;
  logic [3:0] r_crc_cnt;
  logic       r_tx_done;

  logic       w_adv, w_load, w_ready, w_underrun, w_clear;
  logic       w_capture_pkt, w_enter_crc, w_done_set;
  logic [7:0] w_load_byte;
  logic       w_bit, w_last_bit;
  logic [2:0] w_cnt;

  // the bit stuffer may stall line bits, but never the EOP sequence
  assign w_adv = (r_state == ST_EOP) ? tx_shift : (tx_shift & ~tx_hold);

  usb_tx_byte_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_byte     (w_load_byte),
    .i_shift    (w_adv & (r_state != ST_IDLE)),
    .o_bit      (w_bit),
    .o_cnt      (w_cnt),
    .o_last_bit (w_last_bit)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_load_byte   = 8'h00;
    w_ready       = 1'b0;
    w_underrun    = 1'b0;
    w_clear       = 1'b0;
    w_capture_pkt = 1'b0;
    w_enter_crc   = 1'b0;
    w_done_set    = 1'b0;
    case (r_state)
      ST_IDLE: if (pkt_start) begin
        w_clear       = 1'b1;
        w_capture_pkt = 1'b1;
        w_load        = 1'b1;
        w_load_byte   = SYNC_BYTE;
        w_state_nxt   = ST_SYNC;
      end
      ST_SYNC: if (w_last_bit) begin
        w_load      = 1'b1;
        w_load_byte = pid_byte(r_pid);
        w_state_nxt = ST_PID;
      end
      ST_PID: if (w_last_bit) begin
        w_load = 1'b1;
        case (r_kind)
          KIND_DATA: if (data_valid) begin
            w_ready     = 1'b1;
            w_load_byte = data_in;
            w_state_nxt = ST_DATA;
          end else begin
            w_underrun  = 1'b1;
            w_load_byte = J_BYTE;
            w_state_nxt = ST_EOP;
          end
          KIND_ZLP: begin
            w_enter_crc = 1'b1;
            w_load_byte = crc_16[15:8];
            w_state_nxt = ST_CRC;
          end
          KIND_PID_ONLY, KIND_RSVD: begin
            w_load_byte = J_BYTE;
            w_state_nxt = ST_EOP;
          end
        endcase
      end
      ST_DATA: if (w_last_bit) begin
        w_load = 1'b1;
        if (r_last) begin
          w_enter_crc = 1'b1;
          w_load_byte = crc_16[15:8];
          w_state_nxt = ST_CRC;
        end else if (data_valid) begin
          w_ready     = 1'b1;
          w_load_byte = data_in;
        end else begin
          w_underrun  = 1'b1;
          w_load_byte = J_BYTE;
          w_state_nxt = ST_EOP;
        end
      end
      ST_CRC: if (w_adv) begin
        if (r_crc_cnt == 4'd7) begin
          w_load      = 1'b1;
          w_load_byte = r_crc_lo;
        end else if (r_crc_cnt == 4'd15) begin
          w_load      = 1'b1;
          w_load_byte = J_BYTE;
          w_state_nxt = ST_EOP;
        end
      end
      ST_EOP: if (w_adv && (w_cnt == 3'(EOP_BITS - 1))) begin
        w_load      = 1'b1;
        w_load_byte = J_BYTE;
        w_done_set  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pid     <= 4'h0;
      r_kind    <= 2'b00;
      r_last    <= 1'b0;
      r_crc_lo  <= 8'h00;
      r_crc_cnt <= 4'd0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_done <= w_done_set;
      if (w_capture_pkt) begin
        r_pid  <= pkt_pid;
        r_kind <= pkt_kind;
        r_last <= 1'b0;
      end else if (w_ready) begin
        r_last <= data_last;
      end
      if (w_enter_crc) begin
        r_crc_lo  <= crc_16[7:0];
        r_crc_cnt <= 4'd0;
      end else if ((r_state == ST_CRC) && w_adv) begin
        r_crc_cnt <= r_crc_cnt + 4'd1;
      end
    end
  end

  // pulses are masked so nothing leaks out while reset is being applied
  assign data_ready = w_ready & ~rst;
  assign underrun   = w_underrun & ~rst;
  assign crc_clear  = w_clear & ~rst;
  assign crc_enable = (r_state == ST_DATA) & ~rst;
  assign eop_active = (r_state == ST_EOP) & ~rst;
  assign tx_busy    = (r_state != ST_IDLE) & ~rst;
  assign tx_done    = r_tx_done & ~rst;
  assign tx_out_bit = w_bit;

endmodule
`default_nettype wire
